// File: rtl/result_pkg.sv
// Shared types and default widths for the result unloader.
package result_pkg;

  localparam int RES_DATA_W = 16;
  localparam int RES_ADDR_W = 12;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH
  } state_t;

endpackage

// File: rtl/out_skid_buffer.sv
// Two-entry fall-through buffer between the synchronous memory read port and the output.
// An empty buffer passes incoming data straight through so the stream keeps single-cycle latency.
module out_skid_buffer #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              space
);

  logic [DATA_W-1:0] entry [2];
  logic [1:0]        cnt;
  logic              rd_ptr;
  logic              wr_ptr;
  logic              empty;
  logic              wr;
  logic              deq;

  assign empty     = (cnt == 2'd0);
  assign out_valid = !empty || in_valid;
  assign out_data  = empty ? in_data : entry[rd_ptr];
  assign wr        = in_valid && !(empty && out_ready);
  assign deq       = !empty && out_ready;
  // A read issued now lands next cycle; keep room for it even if nothing drains meanwhile.
  assign space     = (cnt + {1'b0, in_valid}) < 2'd2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (wr) wr_ptr <= ~wr_ptr;
      if (deq) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, wr} - {1'b0, deq};
    end
  end

  always_ff @(posedge clk) begin
    if (wr) entry[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/result_unloader.sv
// Streams result_count words starting at result_base from data memory to the host output port
// after a rising edge of proc_done, with back-pressure absorbed by the skid buffer.
module result_unloader
  import result_pkg::*;
#(
  parameter int DATA_W = RES_DATA_W,
  parameter int ADDR_W = RES_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              proc_done,
  input  logic [ADDR_W-1:0] result_base,
  input  logic [ADDR_W:0]   result_count,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              out_hold,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic [DATA_W-1:0] com_data_out,
  output logic              output_write_start,
  output logic              output_write_done,
  output logic              unload_done
);

  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W + 1)'(1);

  state_t            state;
  state_t            state_next;
  logic              proc_done_q;
  logic              trigger;
  logic              empty_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   rd_cnt;
  logic [ADDR_W:0]   xfer_cnt;
  logic              rd_valid_q;
  logic              buf_valid;
  logic              buf_space;
  logic              buf_ready;
  logic [DATA_W-1:0] buf_data;
  logic              xfer;
  logic              last;

  assign trigger      = (state == IDLE) && proc_done && !proc_done_q;
  assign buf_ready    = (state == STREAM) && !out_hold;
  assign xfer         = buf_ready && buf_valid;
  assign last         = (xfer_cnt == count_q - CNT_ONE);
  assign mem_addr     = base_q + rd_cnt[ADDR_W-1:0];
  assign com_data_out = output_write_start ? buf_data : '0;
  assign unload_done  = (state == FLUSH) || empty_q;

  out_skid_buffer #(.DATA_W(DATA_W)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rd_valid_q),
    .in_data   (mem_rdata),
    .out_ready (buf_ready),
    .out_valid (buf_valid),
    .out_data  (buf_data),
    .space     (buf_space)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // Track the live level so a proc_done held high across reset is not seen as an edge.
      proc_done_q <= proc_done;
      empty_q     <= 1'b0;
      base_q      <= '0;
      count_q     <= '0;
      rd_cnt      <= '0;
      xfer_cnt    <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      proc_done_q <= proc_done;
      empty_q     <= trigger && (result_count == '0);
      rd_valid_q  <= mem_rd_en;
      if (trigger) begin
        base_q   <= result_base;
        count_q  <= result_count;
        rd_cnt   <= '0;
        xfer_cnt <= '0;
      end else begin
        if (mem_rd_en) rd_cnt <= rd_cnt + CNT_ONE;
        if (xfer) xfer_cnt <= xfer_cnt + CNT_ONE;
      end
    end
  end

  always_comb begin
    state_next         = state;
    mem_rd_en          = 1'b0;
    output_write_start = 1'b0;
    output_write_done  = 1'b0;
    case (state)
      IDLE: begin
        if (trigger && (result_count != '0)) state_next = STREAM;
      end
      STREAM: begin
        mem_rd_en          = (rd_cnt != count_q) && buf_space;
        output_write_start = buf_valid;
        output_write_done  = buf_valid && last;
        if (xfer && last) state_next = FLUSH;
      end
      FLUSH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_result_unloader.sv
// Self-checking bench for result_unloader: memory model, scoreboard queue of expected words.
module tb_result_unloader;

  localparam int DW = 16;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          proc_done = 1'b0;
  logic [AW-1:0] result_base = '0;
  logic [AW:0]   result_count = '0;
  logic [DW-1:0] mem_rdata = '0;
  logic          out_hold = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en;
  logic [DW-1:0] com_data_out;
  logic          output_write_start;
  logic          output_write_done;
  logic          unload_done;

  logic [DW-1:0] mem [0:4095];
  logic [DW-1:0] exp_q [$];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  result_unloader #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .proc_done          (proc_done),
    .result_base        (result_base),
    .result_count       (result_count),
    .mem_rdata          (mem_rdata),
    .out_hold           (out_hold),
    .mem_addr           (mem_addr),
    .mem_rd_en          (mem_rd_en),
    .com_data_out       (com_data_out),
    .output_write_start (output_write_start),
    .output_write_done  (output_write_done),
    .unload_done        (unload_done)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    proc_done = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({mem_addr, mem_rd_en, com_data_out, output_write_start, output_write_done, unload_done} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got addr=%h rd=%b data=%h start=%b done=%b udone=%b, want all 0",
               mem_addr, mem_rd_en, com_data_out, output_write_start, output_write_done, unload_done);
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({mem_rd_en, output_write_start, unload_done} !== 3'b000) begin
        n_bad++;
        $display("FAIL reset_level_no_trigger: cycle %0d got rd=%b start=%b udone=%b, want 000",
                 c, mem_rd_en, output_write_start, unload_done);
      end
    end
    proc_done = 1'b0;
  endtask

  // Triggers one stream and checks addresses, word order, framing, hold freeze and completion timing.
  task automatic test_stream(input string name, input logic [AW-1:0] base, input int n,
                             input int data0, input logic [31:0] hold_mask);
    int reads, xfers, holds_hit, done_cyc, done_cnt, first_cyc;
    logic          prev_hold;
    logic [DW-1:0] prev_data, w, exp_w;
    logic [AW-1:0] a;
    @(negedge clk);
    proc_done = 1'b0;
    out_hold = 1'b0;
    result_base = base;
    result_count = n[AW:0];
    for (int i = 0; i < n; i++) begin
      a = base + i[AW-1:0];
      w = (data0 >= 0) ? DW'(data0 + i) : DW'($urandom);
      mem[a] = w;
      exp_q.push_back(w);
    end
    @(negedge clk);
    proc_done = 1'b1;
    reads = 0; xfers = 0; holds_hit = 0; done_cyc = -1; done_cnt = 0; first_cyc = -1;
    prev_hold = 1'b0; prev_data = '0;
    for (int c = 1; c <= n + 40; c++) begin
      @(negedge clk);
      out_hold = (c < 32) ? hold_mask[c] : 1'b0;
      if (mem_rd_en) begin
        a = base + reads[AW-1:0];
        n_cmp++;
        if (mem_addr !== a) begin
          n_bad++;
          $display("FAIL %s read_addr: read %0d got %h want %h", name, reads, mem_addr, a);
        end
        reads++;
      end
      if (output_write_start) begin
        if (first_cyc < 0) first_cyc = c;
        if (prev_hold) begin
          n_cmp++;
          if (com_data_out !== prev_data) begin
            n_bad++;
            $display("FAIL %s hold_freeze: cycle %0d got %h want %h", name, c, com_data_out, prev_data);
          end
        end
        if (!out_hold) begin
          exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
          n_cmp++;
          if (com_data_out !== exp_w) begin
            n_bad++;
            $display("FAIL %s word: transfer %0d got %h want %h", name, xfers, com_data_out, exp_w);
          end
          n_cmp++;
          if (output_write_done !== (xfers == n - 1)) begin
            n_bad++;
            $display("FAIL %s write_done: transfer %0d got %b want %b", name, xfers, output_write_done, xfers == n - 1);
          end
          xfers++;
        end else begin
          holds_hit++;
        end
        prev_hold = out_hold;
        prev_data = com_data_out;
      end else begin
        prev_hold = 1'b0;
        if (output_write_done) begin
          n_cmp++;
          n_bad++;
          $display("FAIL %s done_without_start: cycle %0d got done=1 want 0", name, c);
        end
      end
      if (unload_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
    end
    out_hold = 1'b0;
    n_cmp++;
    if (reads != n) begin n_bad++; $display("FAIL %s read_count: got %0d want %0d", name, reads, n); end
    n_cmp++;
    if (xfers != n) begin n_bad++; $display("FAIL %s transfer_count: got %0d want %0d", name, xfers, n); end
    n_cmp++;
    if (first_cyc != 2) begin n_bad++; $display("FAIL %s first_word_cycle: got T+%0d want T+2", name, first_cyc); end
    n_cmp++;
    if (done_cyc != n + 2 + holds_hit) begin
      n_bad++;
      $display("FAIL %s unload_done_cycle: got T+%0d want T+%0d", name, done_cyc, n + 2 + holds_hit);
    end
    n_cmp++;
    if (done_cnt != 1) begin n_bad++; $display("FAIL %s unload_done_pulses: got %0d want 1", name, done_cnt); end
    n_cmp++;
    if (exp_q.size() != 0) begin n_bad++; $display("FAIL %s leftover_words: got %0d want 0", name, exp_q.size()); end
    exp_q.delete();
    proc_done = 1'b0;
  endtask

  task automatic test_basic();
    test_stream("basic", 12'h010, 4, 5, 32'h0);
  endtask

  task automatic test_hold();
    test_stream("hold", 12'h010, 4, 5, 32'h18);
  endtask

  task automatic test_wrap();
    test_stream("wrap", 12'hFFE, 3, 1, 32'h0);
  endtask

  task automatic test_single();
    test_stream("single", 12'h234, 1, -1, 32'h0);
  endtask

  task automatic test_back_to_back();
    test_stream("b2b_hold", 12'h7F0, 12, -1, 32'h0A4C_0120);
  endtask

  task automatic test_empty();
    @(negedge clk);
    proc_done = 1'b0;
    result_count = '0;
    result_base = 12'h055;
    @(negedge clk);
    proc_done = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      n_cmp++;
      if (unload_done !== (c == 1)) begin
        n_bad++;
        $display("FAIL empty_unload_done: cycle T+%0d got %b want %b", c, unload_done, c == 1);
      end
      n_cmp++;
      if ({mem_rd_en, output_write_start} !== 2'b00) begin
        n_bad++;
        $display("FAIL empty_quiet: cycle T+%0d got rd=%b start=%b want 00", c, mem_rd_en, output_write_start);
      end
    end
    proc_done = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] w [8];
    @(negedge clk);
    proc_done = 1'b0;
    result_base = 12'h100;
    result_count = 13'd8;
    for (int i = 0; i < 8; i++) begin
      w[i] = DW'($urandom);
      mem[12'h100 + i] = w[i];
    end
    @(negedge clk);
    proc_done = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (!output_write_start || com_data_out !== w[2]) begin
      n_bad++;
      $display("FAIL mid_word2: got start=%b data=%h want start=1 data=%h", output_write_start, com_data_out, w[2]);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({mem_addr, mem_rd_en, com_data_out, output_write_start, output_write_done, unload_done} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: got addr=%h rd=%b data=%h start=%b done=%b udone=%b, want all 0",
               mem_addr, mem_rd_en, com_data_out, output_write_start, output_write_done, unload_done);
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      n_cmp++;
      if ({mem_rd_en, output_write_start, unload_done} !== 3'b000) begin
        n_bad++;
        $display("FAIL mid_no_restart: cycle %0d got rd=%b start=%b udone=%b want 000",
                 c, mem_rd_en, output_write_start, unload_done);
      end
    end
    test_stream("retrigger", 12'h100, 8, -1, 32'h0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_empty();
    test_wrap();
    test_single();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/result_unloader.md
# result_unloader

Drains the result region of data memory to the host-side output port once every enabled core has finished. It sits directly downstream of the core array and memory controller inside `main`. It reads N consecutive 16-bit words through a single-cycle-latency synchronous read port and presents them on `com_data_out`, one word per transfer, framed by `output_write_start` / `output_write_done`. It supports consumer back-pressure via `out_hold` without losing or duplicating words.

## Interface
- `DATA_W`, 16: word width of memory and output port.
- `ADDR_W`, 12: data-memory address width.
- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `proc_done`  in  1: level from the core controller; all cores selected by `n_cores` have finished.
- `result_base`  in  ADDR_W: address of the first result word, sampled at trigger.
- `result_count`  in  ADDR_W+1: number of words to drain (0 to 2^ADDR_W), sampled at trigger.
- `mem_rdata`  in  DATA_W: read data, valid the cycle after `mem_rd_en`.
- `out_hold`  in  1: consumer stall; presented word is not taken this cycle.
- `mem_addr`  out  ADDR_W: read address.
- `mem_rd_en`  out  1: read strobe.
- `com_data_out`  out  DATA_W: current output word.
- `output_write_start`  out  1: output valid; high from first word through last word inclusive.
- `output_write_done`  out  1: high only while the last word is presented.
- `unload_done`  out  1: one-cycle pulse after the final transfer, or on an empty trigger.

## Operation
- Reset value is 0 for all outputs; FSM resets to IDLE.
- A transfer occurs on any edge where `output_write_start`=1 and `out_hold`=0.
- States:
  - **IDLE**: waits for a `proc_done` rising edge. Uses a registered previous value; a level held high through reset does not trigger. On trigger, latch base and count. If count=0, pulse `unload_done` and stay in IDLE. Otherwise go to STREAM.
  - **STREAM**:
    - Issues reads base, base+1, … while the skid buffer has space.
    - Read counter and transfer counter are separate, each ADDR_W+1 bits.
    - Address wraps modulo 2^ADDR_W.
    - No reads are issued beyond count.
    - `output_write_done`=1 exactly when the presented word is transfer number count−1.
    - The last transfer moves the FSM to FLUSH.
  - **FLUSH**: drops `output_write_start` / `output_write_done`, pulses `unload_done`, then returns to IDLE.
- `out_hold` freezes `com_data_out`, `output_write_start` and `output_write_done`. Read data in flight is captured in the skid buffer and never dropped.
- Changes to `proc_done`, `result_base` or `result_count` after the trigger are ignored until IDLE.
- Reset mid-stream: outputs are 0 at the next edge and the stream is abandoned; there is no `unload_done` pulse.

## Timing
- Trigger sampled at edge T: first `mem_rd_en` at T+1 with `mem_addr`=base; first word valid at T+2.
- With no hold, word k is presented in cycle T+2+k, and the last word at T+1+N with `output_write_done`.
- `unload_done` in cycle T+2+N.
- Each hold cycle delays all later words by exactly one cycle. Throughput is 1 word/cycle after hold release, with no bubble.
- Minimum re-trigger: `proc_done` low for at least one cycle in IDLE, then high.

## Structure
- `result_pkg`: FSM state enum (IDLE, STREAM, FLUSH) and default `DATA_W`/`ADDR_W` constants.
- Sub-module `out_skid_buffer`: 2-entry register buffer, DATA_W wide, with in-valid/out-ready and a `space` flag gating `mem_rd_en`.
- Top level holds the FSM, counters and edge detect.

## Test plan
- Base 0x010, count 4, mem[0x10..0x13] = 5,6,7,8, no hold:
  - trigger at T → reads at T+1..T+4;
  - words 5,6,7,8 at T+2..T+5;
  - `output_write_done` only at T+5;
  - `unload_done` at T+6.
- Same stimulus with `out_hold` high at T+3 and T+4: output sequence 5,6,6,6,7,8; no word lost or repeated as a transfer; `unload_done` at T+8.
- Count 0: `unload_done` pulse at T+1; `mem_rd_en` and `output_write_start` stay 0.
- Base 0xFFE, count 3, mem[0xFFE]=1, mem[0xFFF]=2, mem[0x000]=3: outputs 1,2,3; `mem_addr` wraps to 0.
- Count 1: `output_write_start` and `output_write_done` both high in the same single cycle, T+2.
- `rst_n` low during word 2 of a count-8 stream: all outputs 0 next edge; FSM in IDLE; with `proc_done` still high, no new stream starts until `proc_done` falls and rises again.
